fc_train_sequencer: RTL and testbench
=====================================

Name: fc_train_sequencer

Overview:
Top-level phase controller for one fully connected layer. It steps the layer through forward, weight-gradient backprop, neuron-gradient backprop and batched weight update, in that order. It drives the layer's forward/bp_mode/update/lrate_shifts controls and watches the layer's status strobes. It counts samples per mini-batch, applies the update only at batch end, and flags a watchdog error if any phase stalls.

Parameters:
FWD_BEATS, 8, valid_act_o beats that complete one forward pass (FC1_NEURONS / FC1_N_KERNELS)
PLG_BEATS, 1, pl_grad_valid beats that complete neuron-mode backprop
BATCH_SIZE, 16, samples accumulated before one update phase (>=1)
TIMEOUT, 4096, max cycles in any wait state before error
CNT_W, 13, width of watchdog counter (>= clog2(TIMEOUT+1))

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start_i  in  1  pulse: new sample's activations are about to stream
act_valid_i  in  1  layer valid_act_o
grad_ready_i  in  1  downstream output gradients available for this sample
bp_done_i  in  1  layer bp_done (weight-mode gradient write finished)
pl_grad_valid_i  in  1  layer pl_grad_valid
update_done_i  in  1  layer update_done
lrate_cfg_i  in  5  learning-rate shift request
abort_i  in  1  pulse: abandon current sample/batch, return to IDLE
forward_o  out  1  layer forward
bp_mode_o  out  1  0 = WEIGHT_MODE, 1 = NEURON_MODE
update_o  out  1  layer update
lrate_shifts_o  out  5  shift value held stable for the batch
busy_o  out  1  high in any state except IDLE
sample_done_o  out  1  one-cycle pulse at end of a sample
batch_done_o  out  1  one-cycle pulse when update completes
sample_cnt_o  out  clog2(BATCH_SIZE+1)  samples done in the current batch
error_o  out  1  sticky watchdog flag

Behaviour:
- Reset values: forward_o=1, bp_mode_o=0, update_o=0, lrate_shifts_o=8, busy_o=0, sample_done_o=0, batch_done_o=0, sample_cnt_o=0, error_o=0, state IDLE, all counters 0.
- All outputs are registered. State decode drives them directly, with no combinational input-to-output path.
- States: IDLE, FWD, WAIT_GRAD, BP_W, BP_N, UPD, ERR.
- IDLE: forward_o=1.
  - start_i moves to FWD.
  - If sample_cnt_o==0, latch lrate_shifts_o<=lrate_cfg_i on the same edge. Otherwise lrate_shifts_o is unchanged.
- FWD: forward_o=1. Count act_valid_i beats. On the edge where the count reaches FWD_BEATS, go to WAIT_GRAD and clear the beat counter.
- WAIT_GRAD: forward_o=1.
  - grad_ready_i moves to BP_W.
  - forward_o=0 and bp_mode_o=0 take effect in the first BP_W cycle.
- BP_W: forward_o=0, bp_mode_o=0. bp_done_i moves to BP_N; bp_mode_o=1 takes effect the next cycle.
- BP_N: forward_o=0, bp_mode_o=1. Count pl_grad_valid_i beats. On reaching PLG_BEATS:
  - sample_done_o pulses for 1 cycle.
  - sample_cnt_o increments.
  - If the new count == BATCH_SIZE, go to UPD. Otherwise go to IDLE, with forward_o=1 and bp_mode_o=0.
- UPD: update_o=1, forward_o=0.
  - update_done_i moves to IDLE. update_o drops the following cycle, which also resets the layer's update pointer.
  - On the same edge: batch_done_o pulses, sample_cnt_o<=0.
  - update_o must never be high for fewer than 2 cycles, because the layer writes on odd pointer values.
- Strobes are ignored outside the state that consumes them:
  - act_valid_i outside FWD.
  - bp_done_i outside BP_W.
  - pl_grad_valid_i outside BP_N.
  - update_done_i outside UPD.
  - start_i outside IDLE.
- Watchdog:
  - Counter clears on every state change and on every consumed strobe, and increments otherwise in FWD, WAIT_GRAD, BP_W, BP_N and UPD.
  - When the counter reaches TIMEOUT, go to ERR and set error_o (sticky).
  - ERR outputs match IDLE, except busy_o=1.
  - Only rst clears ERR.
- abort_i (any state except ERR) takes priority over every transition. Next state is IDLE with IDLE outputs, beat counters=0, sample_cnt_o=0, no pulses. An update in progress is abandoned with update_o low the next cycle.
- Simultaneous final beat and abort_i: abort wins, and sample_done_o does not pulse.
- BATCH_SIZE=1: every sample goes BP_N to UPD.
- Reset mid-phase: the next cycle shows reset values regardless of state.

Test Plan:
- Reset, then start_i with FWD_BEATS=8: 8 act_valid_i pulses (gaps allowed) -> WAIT_GRAD; grad_ready_i -> forward_o=0, bp_mode_o=0; bp_done_i -> bp_mode_o=1; 1 pl_grad_valid_i -> sample_done_o 1 cycle, sample_cnt_o=1, back to IDLE with forward_o=1.
- BATCH_SIZE=2, lrate_cfg_i=10 at first start and 7 at second: second sample ends in UPD with update_o=1 and lrate_shifts_o still 10; update_done_i after 784 cycles -> update_o low next cycle, batch_done_o pulse, sample_cnt_o=0.
- Spurious bp_done_i and update_done_i during FWD -> no state change; beat count continues to 8.
- TIMEOUT=64, grad_ready_i withheld -> error_o=1 at cycle 64 of WAIT_GRAD and stays set; start_i is ignored until rst.
- abort_i in UPD at cycle 100 -> update_o=0 next cycle, IDLE, sample_cnt_o=0, no batch_done_o.
- abort_i coincident with the final pl_grad_valid_i -> no sample_done_o, sample_cnt_o=0.

Source files
------------

// File: rtl/fc_train_sequencer.sv
// Phase controller for one fully connected layer: forward, weight-mode backprop,
// neuron-mode backprop and a batched weight update, guarded by a stall watchdog.
module fc_train_sequencer #(
  parameter int FWD_BEATS  = 8,
  parameter int PLG_BEATS  = 1,
  parameter int BATCH_SIZE = 16,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 13
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic                              act_valid_i,
  input  logic                              grad_ready_i,
  input  logic                              bp_done_i,
  input  logic                              pl_grad_valid_i,
  input  logic                              update_done_i,
  input  logic [4:0]                        lrate_cfg_i,
  input  logic                              abort_i,
  output logic                              forward_o,
  output logic                              bp_mode_o,
  output logic                              update_o,
  output logic [4:0]                        lrate_shifts_o,
  output logic                              busy_o,
  output logic                              sample_done_o,
  output logic                              batch_done_o,
  output logic [$clog2(BATCH_SIZE+1)-1:0]   sample_cnt_o,
  output logic                              error_o
);

  localparam int MAX_BEATS = (FWD_BEATS > PLG_BEATS) ? FWD_BEATS : PLG_BEATS;
  localparam int BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int SC_W      = $clog2(BATCH_SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FWD       = 3'd1,
    S_WAIT_GRAD = 3'd2,
    S_BP_W      = 3'd3,
    S_BP_N      = 3'd4,
    S_UPD       = 3'd5,
    S_ERR       = 3'd6
  } state_t;

  state_t            state_r, state_nxt;
  logic [BEAT_W-1:0] beat_r, beat_nxt;
  logic [CNT_W-1:0]  wdog_r, wdog_nxt;
  logic [SC_W-1:0]   cnt_nxt, cnt_inc;
  logic [4:0]        lrate_nxt;
  logic              err_nxt, sdone_nxt, bdone_nxt, consumed, waiting;

  assign cnt_inc = sample_cnt_o + {{(SC_W-1){1'b0}}, 1'b1};

  // Next-state, counters and pulse generation.
  always_comb begin
    state_nxt = state_r;
    beat_nxt  = beat_r;
    wdog_nxt  = wdog_r;
    cnt_nxt   = sample_cnt_o;
    lrate_nxt = lrate_shifts_o;
    err_nxt   = error_o;
    sdone_nxt = 1'b0;
    bdone_nxt = 1'b0;
    consumed  = 1'b0;
    waiting   = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          state_nxt = S_FWD;
          if (sample_cnt_o == {SC_W{1'b0}}) lrate_nxt = lrate_cfg_i;
          else                              lrate_nxt = lrate_shifts_o;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FWD: begin
        waiting = 1'b1;
        if (act_valid_i) begin
          consumed = 1'b1;
          if (beat_r == BEAT_W'(FWD_BEATS - 1)) begin
            state_nxt = S_WAIT_GRAD;
            beat_nxt  = {BEAT_W{1'b0}};
          end else begin
            beat_nxt = beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          beat_nxt = beat_r;
        end
      end
      S_WAIT_GRAD: begin
        waiting = 1'b1;
        if (grad_ready_i) begin
          consumed  = 1'b1;
          state_nxt = S_BP_W;
        end else begin
          state_nxt = S_WAIT_GRAD;
        end
      end
      S_BP_W: begin
        waiting = 1'b1;
        if (bp_done_i) begin
          consumed  = 1'b1;
          state_nxt = S_BP_N;
        end else begin
          state_nxt = S_BP_W;
        end
      end
      S_BP_N: begin
        waiting = 1'b1;
        if (pl_grad_valid_i) begin
          consumed = 1'b1;
          if (beat_r == BEAT_W'(PLG_BEATS - 1)) begin
            beat_nxt  = {BEAT_W{1'b0}};
            sdone_nxt = 1'b1;
            cnt_nxt   = cnt_inc;
            if (cnt_inc == SC_W'(BATCH_SIZE)) state_nxt = S_UPD;
            else                              state_nxt = S_IDLE;
          end else begin
            beat_nxt = beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          beat_nxt = beat_r;
        end
      end
      S_UPD: begin
        waiting = 1'b1;
        // The layer writes on odd pointer values, so update_o must stay high
        // for at least two cycles: a done strobe in the first cycle is ignored.
        if (update_done_i && (wdog_r != {CNT_W{1'b0}})) begin
          consumed  = 1'b1;
          state_nxt = S_IDLE;
          bdone_nxt = 1'b1;
          cnt_nxt   = {SC_W{1'b0}};
        end else begin
          state_nxt = S_UPD;
        end
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt = S_ERR;
        err_nxt   = 1'b1;
      end
    endcase

    if ((state_nxt != state_r) || consumed) begin
      wdog_nxt = {CNT_W{1'b0}};
    end else if (waiting) begin
      if (wdog_r == CNT_W'(TIMEOUT - 1)) begin
        state_nxt = S_ERR;
        err_nxt   = 1'b1;
        beat_nxt  = {BEAT_W{1'b0}};
        wdog_nxt  = {CNT_W{1'b0}};
      end else begin
        wdog_nxt = wdog_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      wdog_nxt = {CNT_W{1'b0}};
    end

    if (abort_i && (state_r != S_ERR)) begin
      state_nxt = S_IDLE;
      beat_nxt  = {BEAT_W{1'b0}};
      wdog_nxt  = {CNT_W{1'b0}};
      cnt_nxt   = {SC_W{1'b0}};
      lrate_nxt = lrate_shifts_o;
      sdone_nxt = 1'b0;
      bdone_nxt = 1'b0;
    end else begin
      cnt_nxt = cnt_nxt;
    end
  end

  // State, counters and outputs; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_IDLE;
      beat_r         <= {BEAT_W{1'b0}};
      wdog_r         <= {CNT_W{1'b0}};
      forward_o      <= 1'b1;
      bp_mode_o      <= 1'b0;
      update_o       <= 1'b0;
      lrate_shifts_o <= 5'd8;
      busy_o         <= 1'b0;
      sample_done_o  <= 1'b0;
      batch_done_o   <= 1'b0;
      sample_cnt_o   <= {SC_W{1'b0}};
      error_o        <= 1'b0;
    end else begin
      state_r        <= state_nxt;
      beat_r         <= beat_nxt;
      wdog_r         <= wdog_nxt;
      forward_o      <= (state_nxt == S_IDLE) || (state_nxt == S_FWD) ||
                        (state_nxt == S_WAIT_GRAD) || (state_nxt == S_ERR);
      bp_mode_o      <= (state_nxt == S_BP_N);
      update_o       <= (state_nxt == S_UPD);
      lrate_shifts_o <= lrate_nxt;
      busy_o         <= (state_nxt != S_IDLE);
      sample_done_o  <= sdone_nxt;
      batch_done_o   <= bdone_nxt;
      sample_cnt_o   <= cnt_nxt;
      error_o        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fc_train_sequencer.sv
// Directed self-checking bench for fc_train_sequencer (BATCH_SIZE=2, TIMEOUT=1024).
module tb_fc_train_sequencer;

  logic       clk = 1'b0;
  logic       rst, start_i, act_valid_i, grad_ready_i, bp_done_i;
  logic       pl_grad_valid_i, update_done_i, abort_i;
  logic [4:0] lrate_cfg_i;
  logic       forward_o, bp_mode_o, update_o, busy_o;
  logic       sample_done_o, batch_done_o, error_o;
  logic [4:0] lrate_shifts_o;
  logic [1:0] sample_cnt_o;

  int errors = 0;
  int checks = 0;

  fc_train_sequencer #(
    .FWD_BEATS(8), .PLG_BEATS(1), .BATCH_SIZE(2), .TIMEOUT(1024), .CNT_W(11)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .act_valid_i(act_valid_i),
    .grad_ready_i(grad_ready_i), .bp_done_i(bp_done_i),
    .pl_grad_valid_i(pl_grad_valid_i), .update_done_i(update_done_i),
    .lrate_cfg_i(lrate_cfg_i), .abort_i(abort_i), .forward_o(forward_o),
    .bp_mode_o(bp_mode_o), .update_o(update_o), .lrate_shifts_o(lrate_shifts_o),
    .busy_o(busy_o), .sample_done_o(sample_done_o), .batch_done_o(batch_done_o),
    .sample_cnt_o(sample_cnt_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_fwd"},   {31'd0, forward_o},     32'd1);
    chk({tag, "_bpm"},   {31'd0, bp_mode_o},     32'd0);
    chk({tag, "_upd"},   {31'd0, update_o},      32'd0);
    chk({tag, "_lr"},    {27'd0, lrate_shifts_o}, 32'd8);
    chk({tag, "_busy"},  {31'd0, busy_o},        32'd0);
    chk({tag, "_sdone"}, {31'd0, sample_done_o}, 32'd0);
    chk({tag, "_bdone"}, {31'd0, batch_done_o},  32'd0);
    chk({tag, "_cnt"},   {30'd0, sample_cnt_o},  32'd0);
    chk({tag, "_err"},   {31'd0, error_o},       32'd0);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      act_valid_i = 1'b1; step(); act_valid_i = 1'b0; step();
    end
  endtask

  // start a sample and walk it into BP_N
  task automatic run_to_bpn(input logic [4:0] cfg);
    lrate_cfg_i = cfg; start_i = 1'b1; step(); start_i = 1'b0;
    beats(8);
    grad_ready_i = 1'b1; step(); grad_ready_i = 1'b0;
    bp_done_i = 1'b1; step(); bp_done_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; act_valid_i = 1'b0; grad_ready_i = 1'b0;
    bp_done_i = 1'b0; pl_grad_valid_i = 1'b0; update_done_i = 1'b0;
    abort_i = 1'b0; lrate_cfg_i = 5'd0;
    step(2);
    chk_reset("reset");
    rst = 1'b0; step();

    // sample 1 with spurious strobes and a premature grad_ready
    lrate_cfg_i = 5'd10; start_i = 1'b1; step(); start_i = 1'b0;
    chk("s1_busy", {31'd0, busy_o}, 32'd1);
    chk("s1_lr", {27'd0, lrate_shifts_o}, 32'd10);
    bp_done_i = 1'b1; update_done_i = 1'b1; step(); bp_done_i = 1'b0; update_done_i = 1'b0;
    chk("spur_fwd", {31'd0, forward_o}, 32'd1);
    chk("spur_upd", {31'd0, update_o}, 32'd0);
    beats(7);
    grad_ready_i = 1'b1; step(); grad_ready_i = 1'b0;
    chk("beat7_fwd", {31'd0, forward_o}, 32'd1);
    beats(1);
    grad_ready_i = 1'b1; step(); grad_ready_i = 1'b0;
    chk("bpw_fwd", {31'd0, forward_o}, 32'd0);
    chk("bpw_bpm", {31'd0, bp_mode_o}, 32'd0);
    bp_done_i = 1'b1; step(); bp_done_i = 1'b0;
    chk("bpn_bpm", {31'd0, bp_mode_o}, 32'd1);
    pl_grad_valid_i = 1'b1; step(); pl_grad_valid_i = 1'b0;
    chk("s1_sdone", {31'd0, sample_done_o}, 32'd1);
    chk("s1_cnt", {30'd0, sample_cnt_o}, 32'd1);
    chk("s1_idle_fwd", {31'd0, forward_o}, 32'd1);
    chk("s1_idle_bpm", {31'd0, bp_mode_o}, 32'd0);
    chk("s1_idle_busy", {31'd0, busy_o}, 32'd0);
    step();
    chk("s1_sdone_1cyc", {31'd0, sample_done_o}, 32'd0);

    // sample 2 completes the batch; lrate held from first sample
    run_to_bpn(5'd7);
    chk("s2_lr", {27'd0, lrate_shifts_o}, 32'd10);
    pl_grad_valid_i = 1'b1; step(); pl_grad_valid_i = 1'b0;
    chk("s2_upd", {31'd0, update_o}, 32'd1);
    chk("s2_fwd", {31'd0, forward_o}, 32'd0);
    chk("s2_cnt", {30'd0, sample_cnt_o}, 32'd2);
    step(783);
    chk("upd_hold", {31'd0, update_o}, 32'd1);
    update_done_i = 1'b1; step(); update_done_i = 1'b0;
    chk("ud_upd", {31'd0, update_o}, 32'd0);
    chk("ud_bdone", {31'd0, batch_done_o}, 32'd1);
    chk("ud_cnt", {30'd0, sample_cnt_o}, 32'd0);
    chk("ud_busy", {31'd0, busy_o}, 32'd0);
    step();
    chk("bdone_1cyc", {31'd0, batch_done_o}, 32'd0);

    // sample 3 normal, sample 4 aborted on its final beat
    run_to_bpn(5'd12);
    pl_grad_valid_i = 1'b1; step(); pl_grad_valid_i = 1'b0;
    chk("s3_cnt", {30'd0, sample_cnt_o}, 32'd1);
    chk("s3_lr", {27'd0, lrate_shifts_o}, 32'd12);
    run_to_bpn(5'd3);
    pl_grad_valid_i = 1'b1; abort_i = 1'b1; step(); pl_grad_valid_i = 1'b0; abort_i = 1'b0;
    chk("abfin_sdone", {31'd0, sample_done_o}, 32'd0);
    chk("abfin_cnt", {30'd0, sample_cnt_o}, 32'd0);
    chk("abfin_busy", {31'd0, busy_o}, 32'd0);

    // samples 5/6 into UPD; early done ignored, then abort at cycle ~100
    run_to_bpn(5'd4);
    pl_grad_valid_i = 1'b1; step(); pl_grad_valid_i = 1'b0;
    chk("s5_cnt", {30'd0, sample_cnt_o}, 32'd1);
    chk("s5_lr", {27'd0, lrate_shifts_o}, 32'd4);
    run_to_bpn(5'd9);
    pl_grad_valid_i = 1'b1; step(); pl_grad_valid_i = 1'b0;
    update_done_i = 1'b1; step(); update_done_i = 1'b0;
    chk("min2_upd", {31'd0, update_o}, 32'd1);
    chk("min2_bdone", {31'd0, batch_done_o}, 32'd0);
    step(98);
    abort_i = 1'b1; step(); abort_i = 1'b0;
    chk("abupd_upd", {31'd0, update_o}, 32'd0);
    chk("abupd_bdone", {31'd0, batch_done_o}, 32'd0);
    chk("abupd_cnt", {30'd0, sample_cnt_o}, 32'd0);
    chk("abupd_busy", {31'd0, busy_o}, 32'd0);
    chk("abupd_fwd", {31'd0, forward_o}, 32'd1);

    // watchdog in WAIT_GRAD: the final beat edge enters cycle 1
    lrate_cfg_i = 5'd6; start_i = 1'b1; step(); start_i = 1'b0;
    beats(7);
    act_valid_i = 1'b1; step(); act_valid_i = 1'b0;
    step(1023);
    chk("wd_pre_err", {31'd0, error_o}, 32'd0);
    step();
    chk("wd_err", {31'd0, error_o}, 32'd1);
    chk("wd_busy", {31'd0, busy_o}, 32'd1);
    chk("wd_fwd", {31'd0, forward_o}, 32'd1);
    start_i = 1'b1; step(); start_i = 1'b0;
    abort_i = 1'b1; step(); abort_i = 1'b0;
    grad_ready_i = 1'b1; step(); grad_ready_i = 1'b0;
    chk("err_sticky", {31'd0, error_o}, 32'd1);
    chk("err_fwd", {31'd0, forward_o}, 32'd1);
    chk("err_busy", {31'd0, busy_o}, 32'd1);
    rst = 1'b1; step(); rst = 1'b0;
    chk_reset("err_rst");

    // reset mid-phase in BP_N with a nonzero sample count
    run_to_bpn(5'd15);
    pl_grad_valid_i = 1'b1; step(); pl_grad_valid_i = 1'b0;
    run_to_bpn(5'd1);
    rst = 1'b1; step();
    chk_reset("mid_rst");
    rst = 1'b0; step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
